// File: rtl/uart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : uart_pkg                                                          |
// | Brief  : Shared UART definitions: FSM encodings, oversampling, tick math.  |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
package uart_pkg;

  localparam int OVERSAMPLE    = 16;
  localparam int NB_OS_COUNTER = $clog2(OVERSAMPLE);

  localparam int NB_STATE = 3;
  localparam logic [NB_STATE-1:0] ST_IDLE   = 3'd0;
  localparam logic [NB_STATE-1:0] ST_START  = 3'd1;
  localparam logic [NB_STATE-1:0] ST_DATA   = 3'd2;
  localparam logic [NB_STATE-1:0] ST_PARITY = 3'd3;
  localparam logic [NB_STATE-1:0] ST_STOP   = 3'd4;

  // Clocks per oversampling tick; truncates, so the line rate is slightly fast.
  function automatic int calc_tick_rate(input int sys_clock, input int baud_rate);
    return sys_clock / (baud_rate * OVERSAMPLE);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_tick.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : uart_baud_tick                                                    |
// | Brief  : Oversampling tick generator with synchronous clear.               |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module uart_baud_tick #(
  parameter int TICK_RATE       = 651,
  parameter int NB_TICK_COUNTER = $clog2(TICK_RATE)
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_clear,
  output logic o_tick
);

  logic [NB_TICK_COUNTER-1:0] r_count;
  logic                       w_wrap;

  assign w_wrap = (r_count == NB_TICK_COUNTER'(TICK_RATE - 1));

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_count <= '0;
    end else if (i_clear || w_wrap) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_tick = w_wrap;

endmodule
`default_nettype wire

// File: rtl/uart_tx_framer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : uart_tx_framer                                                    |
// | Brief  : UART transmitter: start, LSB-first data, optional parity, stop.   |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module uart_tx_framer
  import uart_pkg::*;
#(
  parameter int NB_DATA         = 8,
  parameter int NB_STOP         = 1,
  parameter int BAUD_RATE       = 9600,
  parameter int SYS_CLOCK       = 100000000,
  parameter int TICK_RATE       = calc_tick_rate(SYS_CLOCK, BAUD_RATE),
  parameter int NB_TICK_COUNTER = $clog2(TICK_RATE),
  parameter int NB_DATA_COUNTER = $clog2(NB_DATA),
  parameter int PARITY_EN       = 0,
  parameter int PARITY_ODD      = 0
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_tx_start,
  input  logic [NB_DATA-1:0] i_tx_data,
  output logic               o_tx_data,
  output logic               o_tx_busy,
  output logic               o_tx_done
);

  logic [NB_STATE-1:0]        r_state;
  logic [NB_STATE-1:0]        w_next_state;
  logic [NB_OS_COUNTER-1:0]   r_os_cnt;
  logic [NB_DATA_COUNTER-1:0] r_bit_idx;
  logic [NB_DATA-1:0]         r_shift;
  logic                       r_parity;
  logic                       r_tx_data;
  logic                       r_busy;
  logic                       r_done;

  logic w_tick;
  logic w_accept;
  logic w_bit_end;
  logic w_last_data;
  logic w_last_stop;
  logic w_tx_line;
  logic w_frame_done;

  uart_baud_tick #(
    .TICK_RATE       (TICK_RATE),
    .NB_TICK_COUNTER (NB_TICK_COUNTER)
  ) u_baud_tick (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_clear (w_accept),
    .o_tick  (w_tick)
  );

  assign w_accept    = (r_state == ST_IDLE) && i_tx_start;
  assign w_bit_end   = w_tick && (r_os_cnt == NB_OS_COUNTER'(OVERSAMPLE - 1));
  assign w_last_data = (r_bit_idx == NB_DATA_COUNTER'(NB_DATA - 1));
  assign w_last_stop = (r_bit_idx == NB_DATA_COUNTER'(NB_STOP - 1));

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:   if (i_tx_start) w_next_state = ST_START;
      ST_START:  if (w_bit_end) w_next_state = ST_DATA;
      ST_DATA: begin
        if (w_bit_end && w_last_data) begin
          w_next_state = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: if (w_bit_end) w_next_state = ST_STOP;
      ST_STOP:   if (w_bit_end && w_last_stop) w_next_state = ST_IDLE;
      default:   w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    w_tx_line    = 1'b1;
    w_frame_done = 1'b0;
    case (r_state)
      ST_START:  w_tx_line = 1'b0;
      ST_DATA:   w_tx_line = r_shift[0];
      ST_PARITY: w_tx_line = r_parity;
      ST_STOP:   w_frame_done = w_bit_end && w_last_stop;
      default:   w_tx_line = 1'b1;
    endcase
  end

  // Line, busy and done are flopped so the pin never glitches on state decode.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_tx_data <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_tx_data <= w_tx_line;
      r_busy    <= (w_next_state != ST_IDLE);
      r_done    <= w_frame_done;
    end
  end

  // The bit index is reused to count stop bits, so it restarts on every state change.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_os_cnt  <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_parity  <= 1'b0;
    end else if (w_accept) begin
      r_os_cnt  <= '0;
      r_bit_idx <= '0;
      r_shift   <= i_tx_data;
      r_parity  <= (^i_tx_data) ^ (PARITY_ODD != 0);
    end else if (r_state != ST_IDLE) begin
      if (w_tick) begin
        r_os_cnt <= r_os_cnt + 1'b1;
      end
      if (w_bit_end) begin
        if (w_next_state != r_state) begin
          r_bit_idx <= '0;
        end else begin
          r_bit_idx <= r_bit_idx + 1'b1;
        end
        if (r_state == ST_DATA) begin
          r_shift <= r_shift >> 1;
        end
      end
    end
  end

  assign o_tx_data = r_tx_data;
  assign o_tx_busy = r_busy;
  assign o_tx_done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_framer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_uart_tx_framer                                                 |
// | Brief  : Self-checking bench for uart_tx_framer (plain/even/odd parity).   |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_uart_tx_framer;

  localparam int BIT = 64;   // 16 ticks * TICK_RATE 4

  logic       clk;
  logic       rst_n;
  logic       start [3];
  logic [7:0] din   [3];
  logic       line  [3];
  logic       busy  [3];
  logic       done  [3];
  int         pe_of [3];
  int         po_of [3];

  int tests;
  int failed;

  uart_tx_framer #(.TICK_RATE(4)) dut_plain (
    .i_clock(clk), .i_reset(rst_n), .i_tx_start(start[0]), .i_tx_data(din[0]),
    .o_tx_data(line[0]), .o_tx_busy(busy[0]), .o_tx_done(done[0])
  );

  uart_tx_framer #(.TICK_RATE(4), .PARITY_EN(1), .PARITY_ODD(0)) dut_even (
    .i_clock(clk), .i_reset(rst_n), .i_tx_start(start[1]), .i_tx_data(din[1]),
    .o_tx_data(line[1]), .o_tx_busy(busy[1]), .o_tx_done(done[1])
  );

  uart_tx_framer #(.TICK_RATE(4), .PARITY_EN(1), .PARITY_ODD(1)) dut_odd (
    .i_clock(clk), .i_reset(rst_n), .i_tx_start(start[2]), .i_tx_data(din[2]),
    .o_tx_data(line[2]), .o_tx_busy(busy[2]), .o_tx_done(done[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Frame as the line should carry it: bit 0 = start, then data LSB first, parity, stop.
  function automatic logic [15:0] model_frame(input logic [7:0] d, input int pe, input int po);
    logic [15:0] f;
    f    = '1;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[1+i] = d[i];
    if (pe != 0) f[9] = ((($countones(d) + po) % 2) != 0);
    return f;
  endfunction

  // One frame with a 1-clock start pulse; k counts clocks after the accept edge.
  task automatic send_frame(input int sel, input logic [7:0] d, input int inj_at, input logic [7:0] inj_d);
    logic [15:0] exp;
    int nb, ndone, done_at;
    nb      = 10 + pe_of[sel];
    exp     = model_frame(d, pe_of[sel], po_of[sel]);
    ndone   = 0;
    done_at = -1;
    @(negedge clk);
    start[sel] = 1'b1;
    din[sel]   = d;
    for (int k = 0; k <= nb*BIT + 1; k++) begin
      @(negedge clk);
      if (k == 0) begin
        check($sformatf("latency_hold_s%0d", sel), line[sel], 1'b1);
        check($sformatf("busy_on_s%0d", sel), busy[sel], 1'b1);
        start[sel] = 1'b0;
        din[sel]   = 8'($urandom);
      end
      if (k == 1) check($sformatf("start_fall_s%0d", sel), line[sel], 1'b0);
      if ((k % BIT) == BIT/2 && (k / BIT) < nb)
        check($sformatf("bit%0d_s%0d_d%02h", k / BIT, sel, d), line[sel], exp[k / BIT]);
      if (k == nb*BIT - 1) check($sformatf("busy_end_s%0d", sel), busy[sel], 1'b1);
      if (k == nb*BIT)     check($sformatf("busy_off_s%0d", sel), busy[sel], 1'b0);
      if (done[sel]) begin
        ndone++;
        done_at = k;
      end
      if (inj_at >= 0 && k == inj_at) begin
        start[sel] = 1'b1;
        din[sel]   = inj_d;
      end
      if (inj_at >= 0 && k == inj_at + 1) start[sel] = 1'b0;
    end
    check($sformatf("done_count_s%0d", sel), ndone, 1);
    check($sformatf("done_at_s%0d", sel), done_at, nb*BIT);
  endtask

  typedef struct {
    int         sel;
    logic [7:0] data;
    int         inj_at;
    logic [7:0] inj_data;
  } vec_t;

  vec_t vecs[6];
  logic trace[1400];

  initial begin
    int ndone;
    int done_at[2];
    int gap;
    int a;
    logic [15:0] f1, f2;

    tests  = 0;
    failed = 0;
    pe_of  = '{0, 1, 1};
    po_of  = '{0, 0, 1};
    for (int i = 0; i < 3; i++) begin
      start[i] = 1'b0;
      din[i]   = 8'h00;
    end

    vecs[0] = '{0, 8'h55, -1, 8'h00};
    vecs[1] = '{0, 8'hA3, 200, 8'hFF};
    vecs[2] = '{1, 8'h07, -1, 8'h00};
    vecs[3] = '{2, 8'h07, -1, 8'h00};
    vecs[4] = '{0, 8'h00, 639, 8'hFF};
    vecs[5] = '{2, 8'hFF, 5, 8'h00};

    // Reset and idle line
    rst_n = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      for (int s = 0; s < 3; s++)
        check($sformatf("in_reset_s%0d", s), {line[s], busy[s], done[s]}, 3'b100);
    end
    rst_n = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      for (int s = 0; s < 3; s++)
        check($sformatf("idle_s%0d", s), {line[s], busy[s], done[s]}, 3'b100);
    end

    for (int v = 0; v < 6; v++)
      send_frame(vecs[v].sel, vecs[v].data, vecs[v].inj_at, vecs[v].inj_data);

    // Randomised frames, some with a start pulse landing mid-frame
    for (int r = 0; r < 8; r++) begin
      int s, nb, inj;
      s   = $urandom_range(0, 2);
      nb  = 10 + pe_of[s];
      inj = ($urandom_range(0, 1) != 0) ? $urandom_range(1, nb*BIT - 1) : -1;
      send_frame(s, 8'($urandom), inj, 8'($urandom));
    end

    // Start held high: back-to-back frames 0x0F then 0xF0
    ndone = 0;
    @(negedge clk);
    start[0] = 1'b1;
    din[0]   = 8'h0F;
    for (int k = 0; k < 1300; k++) begin
      @(negedge clk);
      trace[k] = line[0];
      if (done[0]) begin
        if (ndone < 2) done_at[ndone] = k;
        ndone++;
      end
      if (k == 0) din[0] = 8'hF0;
      if (k == 641) start[0] = 1'b0;
    end
    check("b2b_done_count", ndone, 2);
    check("b2b_done0_at", done_at[0], 640);
    check("b2b_done1_at", done_at[1], 1281);
    f1 = model_frame(8'h0F, 0, 0);
    f2 = model_frame(8'hF0, 0, 0);
    a  = 641;
    for (int j = 0; j < 10; j++) begin
      check($sformatf("b2b_f1_bit%0d", j), trace[j*BIT + BIT/2], f1[j]);
      check($sformatf("b2b_f2_bit%0d", j), trace[a + j*BIT + BIT/2], f2[j]);
    end
    gap = 0;
    for (int k = 9*BIT + 1; k < 1300 && trace[k] == 1'b1; k++) gap++;
    check("b2b_gap", gap, BIT + 1);

    // Reset at clock 300 of a 0xA5 frame: line low on data bit 3, then forced high
    @(negedge clk);
    start[0] = 1'b1;
    din[0]   = 8'hA5;
    ndone    = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (k == 0) start[0] = 1'b0;
    end
    check("pre_reset_line", line[0], 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_line_now", line[0], 1'b1);
    check("reset_busy_now", busy[0], 1'b0);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (done[0]) ndone++;
    end
    rst_n = 1'b1;
    for (int c = 0; c < 700; c++) begin
      @(negedge clk);
      if (done[0]) ndone++;
      if (line[0] !== 1'b1 || busy[0] !== 1'b0) ndone++;
    end
    check("reset_no_done", ndone, 0);
    send_frame(0, 8'h3C, -1, 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
`default_nettype wire
